// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode boundary of the MIPS pipeline.
// Holds word width, the NOP encoding, the PC increment and the fetch pair record.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pair_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Bundle of fetch-side and decode-side signals around the prefetch queue.
// The queue itself uses the slave modport; the fetch stage/decoder side uses master.
interface if_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1. Once valid is raised with ready low, the sender holds valid and its
    // payload stable until the transfer. ready never depends on valid on the
    // same side. flush overrides both sides and drops any same-cycle transfer.
    logic                       fetch_valid;
    logic                       fetch_ready;
    logic [XLEN-1:0]            fetch_pc;
    logic [XLEN-1:0]            fetch_instr;
    logic                       flush;
    logic                       dec_valid;
    logic                       dec_ready;
    logic [XLEN-1:0]            dec_pc;
    logic [XLEN-1:0]            dec_instr;
    logic [XLEN-1:0]            dec_pc_plus4;
    logic                       dec_misaligned;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, flush, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr, dec_pc_plus4,
               dec_misaligned, count
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, flush, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr, dec_pc_plus4,
               dec_misaligned, count
    );

endinterface

// File: rtl/sync_fifo_flush.sv
// First-word-fall-through FIFO of fetch pairs with a single-cycle flush.
// Occupancy lives in count; EMPTY/PARTIAL/FULL are just count values.
module sync_fifo_flush
    import mips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  fetch_pair_t       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output fetch_pair_t       out_data,
    output logic [CNT_W-1:0]  count
);

    fetch_pair_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;

    // A full queue refuses a push even when it is popping in the same cycle.
    assign in_ready  = (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];
    assign count     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Storage is never cleared; count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Prefetch queue between instruction fetch and decode: in-order FWFT delivery,
// NOP forcing when empty, pc+4 generation and a misaligned-pc flag.
module if_fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = mips_pkg::XLEN
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_queue_if.slave  bus
);

    fetch_pair_t     in_pair;
    fetch_pair_t     head;
    logic            head_valid;
    logic [XLEN-1:0] head_pc;

    assign in_pair.pc    = bus.fetch_pc;
    assign in_pair.instr = bus.fetch_instr;

    sync_fifo_flush #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.fetch_valid),
        .in_ready  (bus.fetch_ready),
        .in_data   (in_pair),
        .out_valid (head_valid),
        .out_ready (bus.dec_ready),
        .out_data  (head),
        .count     (bus.count)
    );

    // Empty slots may hold stale pairs, so the head is masked to NOP at pc 0.
    assign head_pc            = head_valid ? head.pc : '0;
    assign bus.dec_valid      = head_valid;
    assign bus.dec_pc         = head_pc;
    assign bus.dec_instr      = head_valid ? head.instr : NOP_INSTR;
    assign bus.dec_pc_plus4   = head_pc + PC_STEP;
    assign bus.dec_misaligned = head_valid & (|head_pc[1:0]);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit model_live = 1'b0;

    // Reference: a plain queue of {pc, instr}, head at index 0.
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        if (rst) begin
            exp_q.delete();
            model_live = 1'b1;
        end else if (bus.flush) begin
            exp_q.delete();
        end else begin
            do_pop  = bus.dec_ready && exp_q.size() != 0;
            do_push = bus.fetch_valid && exp_q.size() != DEPTH;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({bus.fetch_pc, bus.fetch_instr});
        end
    end

    always @(negedge clk) begin
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        if (model_live) begin
            v   = exp_q.size() != 0;
            pc  = v ? exp_q[0][63:32] : 32'h0;
            ins = v ? exp_q[0][31:0]  : 32'h0;
            check("m_count",     32'(bus.count), exp_q.size());
            check("m_dec_valid", 32'(bus.dec_valid), 32'(v));
            check("m_fetch_rdy", 32'(bus.fetch_ready), 32'(exp_q.size() != DEPTH));
            check("m_dec_pc",    bus.dec_pc, pc);
            check("m_dec_instr", bus.dec_instr, ins);
            check("m_pc_plus4",  bus.dec_pc_plus4, pc + 32'd4);
            check("m_misalign",  32'(bus.dec_misaligned), 32'(v && pc[1:0] != 2'b00));
        end
    end

    // One clock with the given inputs; returns #1 after the edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic dr, input logic fl);
        bus.fetch_valid = fv;
        bus.fetch_pc    = pc;
        bus.fetch_instr = ins;
        bus.dec_ready   = dr;
        bus.flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},  32'(bus.count), 32'd0);
        check({tag, "_valid"},  32'(bus.dec_valid), 32'd0);
        check({tag, "_pc"},     bus.dec_pc, 32'h0);
        check({tag, "_instr"},  bus.dec_instr, 32'h0);
        check({tag, "_plus4"},  bus.dec_pc_plus4, 32'h4);
        check({tag, "_mis"},    32'(bus.dec_misaligned), 32'd0);
        check({tag, "_fready"}, 32'(bus.fetch_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] next_pc;
        logic [31:0] pc_r;
        logic [31:0] ins_r;
        logic        fv_r;

        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.dec_ready   = 1'b0;
        bus.flush       = 1'b0;

        // Reset then idle
        do_reset();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_reset_values("idle");

        // Single push, visible one cycle later
        step(1'b1, 32'h0040_0000, 32'h1062_0001, 1'b0, 1'b0);
        check("one_valid", 32'(bus.dec_valid), 32'd1);
        check("one_pc",    bus.dec_pc, 32'h0040_0000);
        check("one_instr", bus.dec_instr, 32'h1062_0001);
        check("one_plus4", bus.dec_pc_plus4, 32'h0040_0004);
        check("one_count", 32'(bus.count), 32'd1);

        // Fill to DEPTH, 5th pair refused, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h0040_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        check("full_count",  32'(bus.count), 32'd4);
        check("full_fready", 32'(bus.fetch_ready), 32'd0);
        step(1'b1, 32'h0040_0010, 32'hA000_0004, 1'b0, 1'b0);
        check("held_count", 32'(bus.count), 32'd4);
        check("held_head",  bus.dec_pc, 32'h0040_0000);
        for (int i = 0; i < 4; i++) begin
            check("drain_pc",    bus.dec_pc, 32'h0040_0000 + 32'(4 * i));
            check("drain_instr", bus.dec_instr, 32'hA000_0000 + 32'(i));
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check("drained_valid", 32'(bus.dec_valid), 32'd0);
        check("drained_instr", bus.dec_instr, 32'h0);

        // Steady push+pop at count 2; pointers wrap several times
        do_reset();
        step(1'b1, 32'h0000_1000, 32'hB000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_1004, 32'hB000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("stream_pc", bus.dec_pc, 32'h0000_1000 + 32'(4 * i));
            step(1'b1, 32'h0000_1008 + 32'(4 * i), 32'hB000_0002 + 32'(i), 1'b1, 1'b0);
            check("stream_count", 32'(bus.count), 32'd2);
        end

        // Flush with a simultaneous push drops everything, next push accepted
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h0040_0000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h0040_0010, 32'hC000_0010, 1'b1, 1'b1);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.dec_valid), 32'd0);
        check("flush_instr", bus.dec_instr, 32'h0);
        step(1'b1, 32'h0040_0020, 32'hC000_0020, 1'b0, 1'b0);
        check("post_flush_count", 32'(bus.count), 32'd1);
        check("post_flush_pc",    bus.dec_pc, 32'h0040_0020);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("flush_empty", 32'(bus.count), 32'd0);

        // pc+4 wraps; misaligned flag
        do_reset();
        step(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b0);
        check("wrap_plus4", bus.dec_pc_plus4, 32'h0);
        check("wrap_mis",   32'(bus.dec_misaligned), 32'd0);
        do_reset();
        step(1'b1, 32'h0040_0002, 32'h1234_5678, 1'b0, 1'b0);
        check("mis_flag",  32'(bus.dec_misaligned), 32'd1);
        check("mis_plus4", bus.dec_pc_plus4, 32'h0040_0006);

        // Reset mid-stream overrides push and pop
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h0040_0000 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        step(1'b1, 32'h0040_0030, 32'hD000_0030, 1'b1, 1'b0);
        rst = 1'b0;
        check_reset_values("midrst");

        // Random traffic; a refused pair is held stable until accepted
        next_pc = 32'h0040_0000;
        fv_r = 1'b0;
        pc_r = '0;
        ins_r = '0;
        for (int c = 0; c < 600; c++) begin
            if (!(fv_r && exp_q.size() == DEPTH)) begin
                fv_r  = ($urandom_range(0, 3) != 0);
                pc_r  = ($urandom_range(0, 7) == 0) ? $urandom() : next_pc;
                ins_r = $urandom();
                next_pc = next_pc + 32'd4;
            end
            rst = ($urandom_range(0, 199) == 0);
            step(fv_r, pc_r, ins_r, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 29) == 0));
            rst = 1'b0;
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
